// File: rtl/dpram_gen2.sv
// Dual-port RAM, one write and one read port on a single clock.
// Byte enables, 1/2-cycle read pipeline, collision mode, post-reset clear.
module dpram_gen2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RD_LATENCY     = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    init_done,
  output logic                    access_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;
  logic                    ready;
  logic                    wr_go;
  logic                    rd_go;

  assign ready    = (state == READY);
  assign wr_go    = ready && wr_en;
  assign rd_go    = ready && rd_en;
  assign old_word = mem[wr_addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // Write-through forwards the merged word; read-old sees pre-edge contents.
  assign rd_word = (COLLISION_MODE == 1 && wr_go && wr_addr == rd_addr)
                 ? merged : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready) begin
        mem[cnt] <= '0;
      end else if (wr_go) begin
        mem[wr_addr] <= merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt         <= '0;
      init_done   <= 1'b0;
      access_drop <= 1'b0;
      data_out    <= '0;
      rd_valid    <= 1'b0;
      s1_data     <= '0;
      s1_valid    <= 1'b0;
    end else begin
      access_drop <= !ready && (wr_en || rd_en);
      if (!ready) begin
        cnt <= cnt + 1'b1;
        if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          state     <= READY;
          init_done <= 1'b1;
        end
      end else begin
        init_done <= 1'b1;
      end
      if (RD_LATENCY == 2) begin
        s1_valid <= rd_go;
        if (rd_go) s1_data <= rd_word;
        rd_valid <= s1_valid;
        if (s1_valid) data_out <= s1_data;
      end else begin
        rd_valid <= rd_go;
        if (rd_go) data_out <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dpram_gen2.sv
// Directed bench for dpram_gen2: three builds share one stimulus stream.
// u0: lat1/read-old/clear, u1: lat2/write-through/clear, u2: no clear.
module tb_dpram_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [3:0]  wr_addr;
  logic [31:0] data_in;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] d0, d1, d2;
  logic        v0, v1, v2;
  logic        i0, i1, i2;
  logic        a0, a1, a2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dpram_gen2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1),
               .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(d0), .rd_valid(v0),
    .init_done(i0), .access_drop(a0));

  dpram_gen2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2),
               .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(d1), .rd_valid(v1),
    .init_done(i1), .access_drop(a1));

  dpram_gen2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1),
               .COLLISION_MODE(0), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(d2), .rd_valid(v2),
    .init_done(i2), .access_drop(a2));

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [3:0]  wa;
    logic [31:0] din;
    logic        re;
    logic [3:0]  ra;
    logic        ev0;
    logic [31:0] ed0;
    logic        ev1;
    logic [31:0] ed1;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_be = 4'h0; wr_addr = 4'h0; data_in = '0;
    rd_en = 1'b0; rd_addr = 4'h0;
  endtask

  initial begin
    //               we be    wa    din           re ra    v0 d0            v1 d1
    tbl[0]  = '{1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b1, 4'd2,
                1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 4'h5, 4'd3, 32'h11223344, 1'b1, 4'd3,
                1'b1, 32'hAABBCCDD, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3,
                1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44};
    tbl[3]  = '{1'b1, 4'hF, 4'd7, 32'h5A, 1'b1, 4'd7,
                1'b1, 32'h0, 1'b1, 32'hAA22CC44};
    tbl[4]  = '{1'b1, 4'hF, 4'd0, 32'h10, 1'b1, 4'd7,
                1'b1, 32'h5A, 1'b1, 32'h5A};
    tbl[5]  = '{1'b1, 4'hF, 4'd1, 32'h20, 1'b1, 4'd7,
                1'b1, 32'h5A, 1'b1, 32'h5A};
    tbl[6]  = '{1'b1, 4'hF, 4'd2, 32'h30, 1'b0, 4'd0,
                1'b0, 32'h5A, 1'b1, 32'h5A};
    tbl[7]  = '{1'b1, 4'hF, 4'd15, 32'hDEADBEEF, 1'b0, 4'd0,
                1'b0, 32'h5A, 1'b0, 32'h5A};
    tbl[8]  = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0,
                1'b1, 32'h10, 1'b0, 32'h5A};
    tbl[9]  = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1,
                1'b1, 32'h20, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2,
                1'b1, 32'h30, 1'b1, 32'h20};
    tbl[11] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd15,
                1'b1, 32'hDEADBEEF, 1'b1, 32'h30};
    tbl[12] = '{1'b1, 4'h0, 4'd15, 32'h12345678, 1'b1, 4'd15,
                1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[13] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd15,
                1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[14] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0,
                1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[15] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0,
                1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};

    reset = 1'b1;
    idle();
    step();
    step();
    chk("rst_data", d0, 32'h0);
    chk("rst_valid", {31'b0, v0}, 32'h0);
    chk("rst_init", {31'b0, i0}, 32'h0);
    chk("rst_drop", {31'b0, a0}, 32'h0);

    // First clear, with a rejected write+read sampled at clear edge 5.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd2;
        data_in = 32'h77; rd_en = 1'b1; rd_addr = 4'd2;
      end else begin
        idle();
      end
      step();
      chk($sformatf("clr_init_%0d", k), {31'b0, i0}, {31'b0, k == 16});
      chk($sformatf("clr_init1_%0d", k), {31'b0, i1}, {31'b0, k == 16});
      chk($sformatf("clr_drop_%0d", k), {31'b0, a0}, {31'b0, k == 5});
      chk($sformatf("clr_drop1_%0d", k), {31'b0, a1}, {31'b0, k == 5});
      chk($sformatf("clr_valid_%0d", k), {30'b0, v0, v1}, 32'h0);
    end

    for (int r = 0; r < 16; r++) begin
      wr_en = tbl[r].we; wr_be = tbl[r].be; wr_addr = tbl[r].wa;
      data_in = tbl[r].din; rd_en = tbl[r].re; rd_addr = tbl[r].ra;
      step();
      chk($sformatf("row%0d_v0", r), {31'b0, v0}, {31'b0, tbl[r].ev0});
      chk($sformatf("row%0d_d0", r), d0, tbl[r].ed0);
      chk($sformatf("row%0d_v1", r), {31'b0, v1}, {31'b0, tbl[r].ev1});
      chk($sformatf("row%0d_d1", r), d1, tbl[r].ed1);
      chk($sformatf("row%0d_drop", r), {31'b0, a0}, 32'h0);
    end

    // Fill everything with ones so the next clear is observable.
    for (int a = 0; a < 16; a++) begin
      idle();
      wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'(a);
      data_in = 32'hFFFFFFFF;
      step();
    end

    // Reset with a read in flight in the two-stage pipeline.
    idle();
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    chk("pre_rst_d0", d0, 32'hFFFFFFFF);
    idle();
    reset = 1'b1;
    #1;
    chk("async_init", {31'b0, i0}, 32'h0);
    chk("async_d0", d0, 32'h0);
    chk("async_d1", d1, 32'h0);
    chk("async_v0", {31'b0, v0}, 32'h0);
    step();
    chk("flush_v1a", {31'b0, v1}, 32'h0);
    step();
    chk("flush_v1b", {31'b0, v1}, 32'h0);

    // Reset again part-way through the clear.
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    chk("mid_init_pre", {31'b0, i0}, 32'h0);
    reset = 1'b1;
    #1;
    chk("mid_init", {31'b0, i0}, 32'h0);
    chk("mid_drop", {31'b0, a0}, 32'h0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("re_init_%0d", k), {31'b0, i0}, {31'b0, k == 16});
      chk($sformatf("re_init1_%0d", k), {31'b0, i1}, {31'b0, k == 16});
    end

    for (int a = 0; a < 16; a++) begin
      idle();
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      chk($sformatf("zero_v_%0d", a), {31'b0, v0}, 32'h1);
      chk($sformatf("zero_d_%0d", a), d0, 32'h0);
      chk($sformatf("zero_d1_%0d", a), d1, 32'h0);
      chk($sformatf("keep_d2_%0d", a), d2, 32'hFFFFFFFF);
    end
    idle();
    step();
    chk("tail_v1", {31'b0, v1}, 32'h1);
    chk("tail_drop", {31'b0, a0}, 32'h0);
    step();
    chk("tail_v1_end", {31'b0, v1}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
